running_minimum_with_activation: RTL and testbench
==================================================

# running_minimum_with_activation

Sequential counterpart to the combinational maximum-with-activation compare. It streams candidate upper bounds for one variable, one per accepted beat, and reduces them to a single registered minimum plus an activation flag. A frame is delimited by `in_last`. It sits between the per-constraint upper-bound generators and the bound register feeding the sampler, and completes the interval [max lower bound, min upper bound].

## Interface
- `NUMBER_SIZE`, default 4: width of signed candidate and result, two's complement.
- `COUNT_SIZE`, default 8: width of the active-candidate counter.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  candidate beat present.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_number`  in  NUMBER_SIZE  signed candidate.
- `in_number_activation`  in  1  candidate participates when 1; ignored when 0.
- `in_last`  in  1  final beat of the frame.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes the result.
- `minimum`  out  NUMBER_SIZE  signed minimum of the active candidates.
- `minimum_activation`  out  1  at least one candidate in the frame was active.
- `active_count`  out  COUNT_SIZE  number of active candidates; saturates at all-ones.

## Operation
- A beat is accepted on a cycle with `in_valid & in_ready`.
- There are two states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Internal accumulator: `acc` (signed), `acc_act`, `cnt`. All three clear on entry to ACCUM.
- On an accepted active beat:
  - If `acc_act`=0, or `in_number` < `acc` (signed compare), then `acc` takes `in_number`.
  - `acc_act` is set to 1.
  - `cnt` increments, saturating.
- Ties keep the earlier value; the result is identical either way.
- An accepted inactive beat changes nothing and is not counted.
- Accepting a beat with `in_last`=1 moves ACCUM to HOLD. The outputs register the final value, which already includes that last beat.
- While in HOLD, `minimum`, `minimum_activation` and `active_count` are stable.
- HOLD returns to ACCUM on `out_ready`=1, with the accumulator cleared.
- If no beat in the frame was active: `minimum`=0, `minimum_activation`=0, `active_count`=0.
- A single-beat frame (`in_last` on the first beat) is legal.
- `in_*` inputs are don't-care while in HOLD.
- Reset state and reset values of all outputs: state ACCUM, `in_ready`=1, `out_valid`=0, `minimum`=0, `minimum_activation`=0, `active_count`=0.
- Reset mid-frame or during HOLD discards the partial or pending result. Reset has priority over any simultaneous handshake.

## Timing
- Latency: the last beat is accepted at edge N; `out_valid`=1 from the cycle after edge N.
- HOLD is exited at the edge where `out_ready`=1. `in_ready`=1 in the following cycle.
- There is one idle input cycle per frame; no beat is accepted in the handshake cycle.
- Throughput: one beat per cycle within a frame.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `out_ready` or `in_valid`.
- The compare and accumulator update complete within one cycle. No pipelining is required.

## Test plan
1. Active frame (NUMBER_SIZE=4): 3, -2, 5 (last), all active -> `minimum`=-2, `minimum_activation`=1, `active_count`=3, `out_valid` one cycle after the last beat.
2. Mixed frame: -7 inactive, 4 active, 6 active (last) -> `minimum`=4, `active_count`=2. The inactive -7 is ignored.
3. All inactive: 1, -8 (last), both inactive -> `minimum`=0, `minimum_activation`=0, `active_count`=0.
4. Signed extremes and back-to-back frames:
   - Frame A: 7, -8 (last) -> `minimum`=-8.
   - Frame B: 7 (last) -> `minimum`=7.
   - Frame B's result must not leak from frame A.
5. Backpressure: hold `out_ready`=0 for 3 cycles after `out_valid` -> outputs stable, `in_ready`=0, and beats driven with `in_valid`=1 are not accepted. The frame completes when `out_ready` rises.
6. Reset mid-frame:
   - Accept 2 and -3, then pulse `reset` for one cycle.
   - Send 5 (last) -> `minimum`=5, `active_count`=1.
   - All outputs read 0 and `in_ready`=1 in the cycle after reset.

Source files
------------

// File: rtl/running_minimum_with_activation.sv
// Streams signed candidate upper bounds and reduces each in_last-delimited frame
// to a registered minimum, an activation flag and a saturating active count.
module running_minimum_with_activation #(
  parameter int NUMBER_SIZE = 4,
  parameter int COUNT_SIZE  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [NUMBER_SIZE-1:0] in_number,
  input  logic                          in_number_activation,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [NUMBER_SIZE-1:0] minimum,
  output logic                          minimum_activation,
  output logic [COUNT_SIZE-1:0]         active_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                        r_state;
  logic signed [NUMBER_SIZE-1:0] r_acc;
  logic                          r_acc_act;
  logic [COUNT_SIZE-1:0]         r_cnt;

  logic                          w_take;
  logic signed [NUMBER_SIZE-1:0] w_acc_nxt;
  logic                          w_act_nxt;
  logic [COUNT_SIZE-1:0]         w_cnt_nxt;

  // Handshake signals come from registered state only.
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign w_take    = in_valid & in_ready;

  // Next accumulator value including the current beat; ties keep the earlier value.
  always_comb begin
    w_acc_nxt = r_acc;
    w_act_nxt = r_acc_act;
    w_cnt_nxt = r_cnt;
    if (w_take && in_number_activation) begin
      if (!r_acc_act || (in_number < r_acc)) begin
        w_acc_nxt = in_number;
      end
      w_act_nxt = 1'b1;
      if (r_cnt != {COUNT_SIZE{1'b1}}) begin
        w_cnt_nxt = r_cnt + {{(COUNT_SIZE-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= ACCUM;
      r_acc              <= '0;
      r_acc_act          <= 1'b0;
      r_cnt              <= '0;
      minimum            <= '0;
      minimum_activation <= 1'b0;
      active_count       <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          r_acc     <= w_acc_nxt;
          r_acc_act <= w_act_nxt;
          r_cnt     <= w_cnt_nxt;
          if (w_take && in_last) begin
            r_state            <= HOLD;
            minimum            <= w_acc_nxt;
            minimum_activation <= w_act_nxt;
            active_count       <= w_cnt_nxt;
          end
        end
        HOLD: begin
          // Clearing here means the next frame starts clean on entry to ACCUM.
          if (out_ready) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_acc_act <= 1'b0;
            r_cnt     <= '0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_running_minimum_with_activation.sv
// Directed-vector bench for running_minimum_with_activation (NUMBER_SIZE=4, COUNT_SIZE=8).
module tb_running_minimum_with_activation;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] in_number;
  logic              in_number_activation;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic signed [3:0] minimum;
  logic              minimum_activation;
  logic [7:0]        active_count;

  int n_tests;
  int n_fail;

  running_minimum_with_activation #(
    .NUMBER_SIZE(4),
    .COUNT_SIZE (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_number           (in_number),
    .in_number_activation(in_number_activation),
    .in_last             (in_last),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .minimum             (minimum),
    .minimum_activation  (minimum_activation),
    .active_count        (active_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one clock edge; caller is in ACCUM.
  task automatic beat(input int n, input bit act, input bit last);
    logic [31:0] v;
    v = n;
    in_valid             = 1'b1;
    in_number            = v[3:0];
    in_number_activation = act;
    in_last              = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Check a held result, then consume it and check the return to ACCUM.
  task automatic expect_result(input string tag, input int mn, input int act, input int cnt);
    chk({tag, ".out_valid"}, int'(out_valid), 1);
    chk({tag, ".in_ready"},  int'(in_ready), 0);
    chk({tag, ".minimum"},   int'(minimum), mn);
    chk({tag, ".min_act"},   int'(minimum_activation), act);
    chk({tag, ".count"},     int'(active_count), cnt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".ready_back"}, int'(in_ready), 1);
    chk({tag, ".valid_drop"}, int'(out_valid), 0);
  endtask

  initial begin
    n_tests              = 0;
    n_fail               = 0;
    reset                = 1'b1;
    in_valid             = 1'b0;
    in_number            = '0;
    in_number_activation = 1'b0;
    in_last              = 1'b0;
    out_ready            = 1'b0;
    tick();
    tick();
    chk("rst.in_ready",  int'(in_ready), 1);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.minimum",   int'(minimum), 0);
    chk("rst.min_act",   int'(minimum_activation), 0);
    chk("rst.count",     int'(active_count), 0);
    reset = 1'b0;
    tick();

    // 1: all active
    beat(3, 1, 0);
    beat(-2, 1, 0);
    chk("t1.no_early_valid", int'(out_valid), 0);
    beat(5, 1, 1);
    expect_result("t1", -2, 1, 3);

    // 2: inactive -7 ignored
    beat(-7, 0, 0);
    beat(4, 1, 0);
    beat(6, 1, 1);
    expect_result("t2", 4, 1, 2);

    // 3: all inactive
    beat(1, 0, 0);
    beat(-8, 0, 1);
    expect_result("t3", 0, 0, 0);

    // 4: signed extremes, back-to-back frames
    beat(7, 1, 0);
    beat(-8, 1, 1);
    expect_result("t4a", -8, 1, 2);
    beat(7, 1, 1);
    expect_result("t4b", 7, 1, 1);

    // Tie keeps the same value
    beat(-3, 1, 0);
    beat(-3, 1, 1);
    expect_result("tie", -3, 1, 2);

    // 5: backpressure with a beat offered during HOLD
    beat(-1, 1, 1);
    in_valid             = 1'b1;
    in_number            = 4'sd0 - 4'sd5;
    in_number_activation = 1'b1;
    in_last              = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5.hold_valid",  int'(out_valid), 1);
      chk("t5.hold_ready",  int'(in_ready), 0);
      chk("t5.hold_min",    int'(minimum), -1);
      chk("t5.hold_count",  int'(active_count), 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk("t5.ready_back", int'(in_ready), 1);
    beat(2, 1, 1);
    expect_result("t5.next", 2, 1, 1);

    // 6: reset mid-frame
    beat(2, 1, 0);
    beat(-3, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6.in_ready",  int'(in_ready), 1);
    chk("t6.out_valid", int'(out_valid), 0);
    chk("t6.minimum",   int'(minimum), 0);
    chk("t6.min_act",   int'(minimum_activation), 0);
    chk("t6.count",     int'(active_count), 0);
    beat(5, 1, 1);
    expect_result("t6", 5, 1, 1);

    // Counter saturation: 300 active beats
    for (int i = 0; i < 299; i++) beat(i % 8, 1, 0);
    beat(-4, 1, 1);
    expect_result("sat", -4, 1, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
